// File: rtl/arquitetura_nios2_qsys_0_oci_trace_capture.sv
// Trace capture ring buffer. Writes become visible after 1 cycle and reads are show-ahead.
// There is no backpressure on writes: when the buffer is full, WRAP_MODE selects whether the oldest entry or the new word is lost.
module arquitetura_nios2_qsys_0_oci_trace_capture #(
  parameter int DATA_W    = 30,
  parameter int CNT_W     = 4,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  parameter int WRAP_MODE = 1,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_W-1:0]       dct_buffer,
  input  logic [CNT_W-1:0]        dct_count,
  input  logic                    dct_valid,
  input  logic                    test_ending,
  input  logic                    test_has_ended,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [DATA_W+CNT_W-1:0] rd_data,
  output logic [ADDR_W:0]         fill_level,
  output logic                    overflow,
  output logic [1:0]              cap_state
);

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'b00,
    ST_POST    = 2'b01,
    ST_FROZEN  = 2'b10
  } cap_state_t;

  localparam logic [ADDR_W:0] FILL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] POST_LOAD = (ADDR_W+1)'(POST_TRIG);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_ZERO  = '0;

  cap_state_t              state_q, state_d;
  logic [ADDR_W:0]         post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]         fill_q;
  logic                    ovf_q;
  logic [DATA_W+CNT_W-1:0] mem [DEPTH];

  logic wr_en;
  logic pop;
  logic full;
  logic store;
  logic adv_rd;
  logic ovf_set;

  assign wr_en   = dct_valid && (state_q != ST_FROZEN);
  assign pop     = rd_valid && rd_ready;
  assign full    = (fill_q == FILL_FULL);
  // A write into a full buffer is stored only if a pop frees a slot or wrap mode evicts the oldest entry.
  assign store   = wr_en && (!full || pop || (WRAP_MODE != 0));
  assign adv_rd  = pop || (wr_en && full && (WRAP_MODE != 0));
  assign ovf_set = wr_en && full && !pop;

  assign rd_valid   = (fill_q != CNT_ZERO);
  assign rd_data    = mem[rd_ptr_q];
  assign fill_level = fill_q;
  assign overflow   = ovf_q;
  assign cap_state  = state_q;

  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr_q] <= {dct_count, dct_buffer};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (store) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (adv_rd) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (wr_en && !pop && !full) begin
        fill_q <= fill_q + 1'b1;
      end else if (!wr_en && pop) begin
        fill_q <= fill_q - 1'b1;
      end
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_CAPTURE;
      post_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      post_cnt_q <= post_cnt_d;
    end
  end

  // Post-trigger count includes writes dropped in no-wrap mode; the write that trips the counter is the last captured.
  always_comb begin
    state_d    = state_q;
    post_cnt_d = post_cnt_q;
    case (state_q)
      ST_CAPTURE: begin
        if (test_has_ended) begin
          state_d = ST_FROZEN;
        end else if (test_ending) begin
          if (POST_TRIG == 0) begin
            state_d = ST_FROZEN;
          end else begin
            state_d    = ST_POST;
            post_cnt_d = POST_LOAD;
          end
        end
      end
      ST_POST: begin
        if (test_has_ended || (post_cnt_q == CNT_ZERO)) begin
          state_d = ST_FROZEN;
        end else if (wr_en) begin
          post_cnt_d = post_cnt_q - 1'b1;
          if (post_cnt_q == CNT_ONE) begin
            state_d = ST_FROZEN;
          end
        end
      end
      ST_FROZEN: begin
        state_d = ST_FROZEN;
      end
      default: begin
        state_d = ST_FROZEN;
      end
    endcase
  end

endmodule

// File: tb/tb_arquitetura_nios2_qsys_0_oci_trace_capture.sv
// Directed bench: wrap, no-wrap and zero-post-trigger instances share one stimulus stream.
module tb_arquitetura_nios2_qsys_0_oci_trace_capture;

  logic        clk;
  logic        reset_n;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        test_ending;
  logic        test_has_ended;
  logic        rd_ready;

  logic        w_rd_valid, d_rd_valid, z_rd_valid;
  logic [33:0] w_rd_data, d_rd_data, z_rd_data;
  logic [4:0]  w_fill, d_fill, z_fill;
  logic        w_ovf, d_ovf, z_ovf;
  logic [1:0]  w_state, d_state, z_state;

  int checks   = 0;
  int failures = 0;
  bit collect  = 1'b0;
  logic [33:0] drained[$];

  arquitetura_nios2_qsys_0_oci_trace_capture #(.WRAP_MODE(1)) dut_w (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_ready(rd_ready), .rd_valid(w_rd_valid), .rd_data(w_rd_data),
    .fill_level(w_fill), .overflow(w_ovf), .cap_state(w_state));

  arquitetura_nios2_qsys_0_oci_trace_capture #(.WRAP_MODE(0)) dut_d (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_ready(rd_ready), .rd_valid(d_rd_valid), .rd_data(d_rd_data),
    .fill_level(d_fill), .overflow(d_ovf), .cap_state(d_state));

  arquitetura_nios2_qsys_0_oci_trace_capture #(.POST_TRIG(0)) dut_z (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_ready(rd_ready), .rd_valid(z_rd_valid), .rd_data(z_rd_data),
    .fill_level(z_fill), .overflow(z_ovf), .cap_state(z_state));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [33:0] word(input int i);
    logic [31:0] u;
    u = i;
    return {u[3:0] ^ 4'h5, u[29:0] + 30'h0123_4500};
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input int idx, input logic rdy, input logic te, input logic th);
    logic [33:0] w;
    w = word(idx);
    dct_valid      = v;
    dct_buffer     = w[29:0];
    dct_count      = w[33:30];
    rd_ready       = rdy;
    test_ending    = te;
    test_has_ended = th;
    #1;
    if (collect && w_rd_valid && rd_ready) drained.push_back(w_rd_data);
    @(posedge clk);
    #1;
  endtask

  task automatic rst();
    reset_n = 1'b0;
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; dct_buffer = '0; dct_count = '0; dct_valid = 1'b0;
    test_ending = 1'b0; test_has_ended = 1'b0; rd_ready = 1'b0;

    rst();
    chk("rst_fill",  64'(w_fill), 64'd0);
    chk("rst_valid", 64'(w_rd_valid), 64'd0);
    chk("rst_ovf",   64'(w_ovf), 64'd0);
    chk("rst_state", 64'(w_state), 64'd0);
    chk("rst_state_d", 64'(d_state), 64'd0);

    // Basic show-ahead ordering and single-cycle write latency.
    cyc(1'b1, 0, 1'b0, 1'b0, 1'b0);
    chk("lat_fill1",  64'(w_fill), 64'd1);
    chk("lat_valid1", 64'(w_rd_valid), 64'd1);
    cyc(1'b1, 1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2, 1'b0, 1'b0, 1'b0);
    chk("abc_fill", 64'(w_fill), 64'd3);
    chk("abc_head", 64'(w_rd_data), 64'(word(0)));
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("pop_fill", 64'(w_fill), 64'd2);
    chk("pop_head", 64'(w_rd_data), 64'(word(1)));

    // 18 writes into 16 entries: wrap keeps newest, no-wrap keeps oldest.
    rst();
    for (int i = 0; i < 18; i++) cyc(1'b1, i, 1'b0, 1'b0, 1'b0);
    chk("wrap_fill", 64'(w_fill), 64'd16);
    chk("wrap_ovf",  64'(w_ovf), 64'd1);
    chk("wrap_head", 64'(w_rd_data), 64'(word(2)));
    chk("drop_fill", 64'(d_fill), 64'd16);
    chk("drop_ovf",  64'(d_ovf), 64'd1);
    chk("drop_head", 64'(d_rd_data), 64'(word(0)));
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("wrap_drain%0d", k), 64'(w_rd_data), 64'(word(2 + k)));
      chk($sformatf("drop_drain%0d", k), 64'(d_rd_data), 64'(word(k)));
      cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    end
    chk("wrap_empty", 64'(w_rd_valid), 64'd0);
    chk("drop_empty", 64'(d_rd_valid), 64'd0);
    chk("wrap_ovf_sticky", 64'(w_ovf), 64'd1);

    // Reset in the middle of POST clears everything including sticky overflow.
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("trig_post", 64'(w_state), 64'd1);
    chk("z_trig_frozen", 64'(z_state), 64'd2);
    for (int i = 0; i < 3; i++) cyc(1'b1, i, 1'b0, 1'b0, 1'b0);
    chk("post3_state", 64'(w_state), 64'd1);
    chk("post3_fill",  64'(w_fill), 64'd3);
    chk("z_frozen_fill", 64'(z_fill), 64'd0);
    reset_n = 1'b0;
    cyc(1'b1, 3, 1'b1, 1'b1, 1'b0);
    reset_n = 1'b1;
    chk("mid_rst_state", 64'(w_state), 64'd0);
    chk("mid_rst_fill",  64'(w_fill), 64'd0);
    chk("mid_rst_ovf",   64'(w_ovf), 64'd0);
    chk("mid_rst_valid", 64'(w_rd_valid), 64'd0);
    chk("mid_rst_z",     64'(z_state), 64'd0);

    // Full buffer with simultaneous write and pop must not overflow.
    for (int i = 0; i < 16; i++) cyc(1'b1, i, 1'b0, 1'b0, 1'b0);
    chk("full_fill", 64'(w_fill), 64'd16);
    chk("full_ovf",  64'(w_ovf), 64'd0);
    cyc(1'b1, 16, 1'b1, 1'b0, 1'b0);
    chk("wp_fill",   64'(w_fill), 64'd16);
    chk("wp_ovf",    64'(w_ovf), 64'd0);
    chk("wp_head",   64'(w_rd_data), 64'(word(1)));
    chk("wp_ovf_d",  64'(d_ovf), 64'd0);
    chk("wp_head_d", 64'(d_rd_data), 64'(word(1)));
    cyc(1'b1, 17, 1'b0, 1'b0, 1'b0);
    chk("wnp_ovf_w",  64'(w_ovf), 64'd1);
    chk("wnp_head_w", 64'(w_rd_data), 64'(word(2)));
    chk("wnp_ovf_d",  64'(d_ovf), 64'd1);
    chk("wnp_head_d", 64'(d_rd_data), 64'(word(1)));

    // Post-trigger window: 5 pre + 8 post words survive, 9th and 10th are refused.
    rst();
    collect = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b1, i, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
    chk("win_post", 64'(w_state), 64'd1);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("win_state%0d", k), 64'(w_state), (k < 8) ? 64'd1 : 64'd2);
      cyc(1'b1, 5 + k, 1'b1, 1'b0, 1'b0);
    end
    chk("win_frozen", 64'(w_state), 64'd2);
    for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    collect = 1'b0;
    chk("win_count", 64'(drained.size()), 64'd13);
    for (int j = 0; j < 13; j++) begin
      if (j < drained.size()) chk($sformatf("win_word%0d", j), 64'(drained[j]), 64'(word(j)));
      else chk($sformatf("win_word%0d", j), 64'hdead, 64'(word(j)));
    end
    chk("win_empty", 64'(w_rd_valid), 64'd0);

    // Immediate freeze wins over trigger and still accepts that cycle's write.
    rst();
    cyc(1'b1, 20, 1'b0, 1'b1, 1'b1);
    chk("he_state", 64'(w_state), 64'd2);
    chk("he_fill",  64'(w_fill), 64'd1);
    chk("he_head",  64'(w_rd_data), 64'(word(20)));
    chk("he_head_z", 64'(z_rd_data), 64'(word(20)));
    cyc(1'b1, 21, 1'b0, 1'b1, 1'b0);
    chk("frz_fill",  64'(w_fill), 64'd1);
    chk("frz_state", 64'(w_state), 64'd2);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("frz_pop_fill", 64'(w_fill), 64'd0);
    chk("frz_pop_z",    64'(z_rd_valid), 64'd0);
    chk("frz_z_ovf",    64'(z_ovf), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arquitetura_nios2_qsys_0_oci_trace_capture.md
ARQUITETURA_NIOS2_QSYS_0_OCI_TRACE_CAPTURE -- requirements
Module: arquitetura_nios2_qsys_0_oci_trace_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 30, width of dct_buffer trace word.
REQ-002 SHALL have parameter CNT_W, default 4, width of dct_count tag.
REQ-003 SHALL have parameter DEPTH, default 16, buffer entries, power of two, >= 2; ADDR_W = log2(DEPTH).
REQ-004 SHALL have parameter POST_TRIG, default 8, range 0..DEPTH, entries captured after the trigger.
REQ-005 SHALL have parameter WRAP_MODE, default 1: 1 = overwrite oldest when full, 0 = drop new when full.
REQ-006 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port dct_buffer  input  DATA_W  trace word.
REQ-009 SHALL have port dct_count  input  CNT_W  trace word tag.
REQ-010 SHALL have port dct_valid  input  1  dct_buffer/dct_count valid this cycle.
REQ-011 SHALL have port test_ending  input  1  trigger; starts post-trigger capture.
REQ-012 SHALL have port test_has_ended  input  1  immediate freeze request.
REQ-013 SHALL have port rd_ready  input  1  reader accepts rd_data this cycle.
REQ-014 SHALL have port rd_valid  output  1  buffer non-empty.
REQ-015 SHALL have port rd_data  output  DATA_W+CNT_W  oldest entry, {dct_count, dct_buffer}.
REQ-016 SHALL have port fill_level  output  ADDR_W+1  occupied entries, 0..DEPTH.
REQ-017 SHALL have port overflow  output  1  sticky; a write hit a full buffer.
REQ-018 SHALL have port cap_state  output  2  00 CAPTURE, 01 POST, 10 FROZEN.

Function
REQ-019 SHALL accept a write when dct_valid=1 and cap_state != FROZEN.
REQ-020 SHALL present rd_data show-ahead (combinational from read pointer); rd_valid = (fill_level != 0).
REQ-021 SHALL pop on rd_valid & rd_ready, in any state including FROZEN.
REQ-022 SHALL make an accepted write visible on rd_valid/fill_level the next cycle (1-cycle latency).
REQ-023 SHALL, on write + pop same cycle, keep fill_level unchanged and set no overflow, even when full.
REQ-024 SHALL, on write to full buffer without pop, WRAP_MODE=1: store word, advance read pointer, fill stays DEPTH, set overflow.
REQ-025 SHALL, on write to full buffer without pop, WRAP_MODE=0: discard word, pointers unchanged, set overflow.
REQ-026 SHALL wrap read/write pointers modulo DEPTH; fill_level never exceeds DEPTH or goes below 0.
REQ-027 SHALL transition CAPTURE->POST on test_ending=1, loading post counter with POST_TRIG; a write that same cycle is accepted but not counted.
REQ-028 SHALL, when POST_TRIG=0, transition CAPTURE->FROZEN directly on test_ending.
REQ-029 SHALL in POST decrement post counter per accepted write (including dropped writes in WRAP_MODE=0) and enter FROZEN on the cycle after counter reaches 0.
REQ-030 SHALL transition any state->FROZEN on test_has_ended=1; priority over test_ending; a write that same cycle is accepted.
REQ-031 SHALL ignore test_ending in POST and FROZEN; FROZEN exits only by reset.
REQ-032 SHALL keep overflow set until reset.

Reset
REQ-033 SHALL, when reset_n=0 at a clk edge, set pointers 0, fill_level 0, rd_valid 0, overflow 0, cap_state CAPTURE, post counter 0.
REQ-034 SHALL give reset priority over all writes, pops and state transitions, including mid-POST; buffer contents need not be cleared.

Verification
REQ-035 Defaults; write 3 words A,B,C, rd_ready=0 -> fill_level 3, rd_data=A; pulse rd_ready one cycle -> rd_data=B, fill_level 2.
REQ-036 WRAP_MODE=1: write 18 words 0..17, no reads -> fill_level 16, overflow 1, rd_data=word 2; drain yields 2..17 in order.
REQ-037 WRAP_MODE=0: write 18 words -> fill_level 16, overflow 1, drain yields 0..15.
REQ-038 Full buffer, write+pop same cycle -> fill_level stays 16, overflow stays 0.
REQ-039 Write 5, pulse test_ending, write 10 more continuously, reading all -> cap_state POST for 8 writes then FROZEN; 9th/10th post writes absent from drained output.
REQ-040 In POST with 3 writes counted, assert reset_n=0 one cycle -> next cycle cap_state CAPTURE, fill_level 0, overflow 0, rd_valid 0.
